// File: rtl/sdram_burst_arbiter.sv
// Burst scheduler for two ping-pong channels sharing one sdram_ctrl.
// Round-robins among W0/R0/W1/R1, builds the burst start address and
// tracks which ping-pong half of each channel holds unread data.
module sdram_burst_arbiter #(
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned BUF_WORDS = 1024,
    parameter int unsigned ADDR_W    = 22,
    parameter int unsigned USEDW_W   = 11,
    parameter int unsigned RD_LOW_WM = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ctrl_idle,
    input  logic               cmd_ack,
    input  logic [USEDW_W-1:0] w0_usedw,
    input  logic [USEDW_W-1:0] r0_usedw,
    input  logic [USEDW_W-1:0] w1_usedw,
    input  logic [USEDW_W-1:0] r1_usedw,
    input  logic [1:0]         ch_clr,
    output logic               sys_w_req,
    output logic               sys_r_req,
    output logic [ADDR_W-1:0]  sys_wr_addr,
    output logic [1:0]         gnt_id,
    output logic               gnt_valid,
    output logic [1:0]         rd_ready,
    output logic [1:0]         w_stall
);

    localparam int unsigned OFF_W  = $clog2(BUF_WORDS);
    localparam int unsigned OFFA_W = ADDR_W - 2;
    localparam logic [OFF_W-1:0]   LAST_OFF    = OFF_W'(BUF_WORDS - BURST_LEN);
    localparam logic [OFF_W-1:0]   BURST_INC   = OFF_W'(BURST_LEN);
    localparam logic [USEDW_W-1:0] BURST_WORDS = USEDW_W'(BURST_LEN);
    localparam logic [USEDW_W-1:0] RD_WM       = USEDW_W'(RD_LOW_WM);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

    state_t            state;
    logic [1:0]        rr_ptr;
    logic [OFF_W-1:0]  wr_off [2];
    logic [OFF_W-1:0]  rd_off [2];
    logic [1:0]        wr_half;
    logic [1:0]        rd_half;
    logic [1:0]        half_valid [2];
    logic [1:0]        clr_pend;

    logic [1:0]        wreq;
    logic [1:0]        rreq;
    logic [1:0]        stall_now;
    logic [3:0]        req_vec;
    logic [1:0]        idx;
    logic              pick_valid;
    logic [1:0]        pick_id;
    logic              pick_ch;
    logic              pick_rd;
    logic              pick_half;
    logic [OFF_W-1:0]  pick_off;
    logic [ADDR_W-1:0] pick_addr;
    logic              grant_now;
    logic [1:0]        ch_busy;
    logic              gch;

    // Request evaluation, round-robin pick and address of the candidate burst
    always_comb begin
        wreq       = '0;
        rreq       = '0;
        stall_now  = '0;
        idx        = '0;
        pick_valid = 1'b0;
        pick_id    = rr_ptr;
        ch_busy    = '0;

        wreq[0]      = (w0_usedw >= BURST_WORDS) && !half_valid[0][wr_half[0]];
        wreq[1]      = (w1_usedw >= BURST_WORDS) && !half_valid[1][wr_half[1]];
        rreq[0]      = half_valid[0][rd_half[0]] && (r0_usedw <= RD_WM);
        rreq[1]      = half_valid[1][rd_half[1]] && (r1_usedw <= RD_WM);
        stall_now[0] = (w0_usedw >= BURST_WORDS) && half_valid[0][wr_half[0]];
        stall_now[1] = (w1_usedw >= BURST_WORDS) && half_valid[1][wr_half[1]];
        req_vec      = {rreq[1], wreq[1], rreq[0], wreq[0]};

        for (int i = 0; i < 4; i++) begin
            idx = rr_ptr + 2'(i);
            if (!pick_valid && req_vec[idx]) begin
                pick_valid = 1'b1;
                pick_id    = idx;
            end
        end

        pick_ch   = pick_id[1];
        pick_rd   = pick_id[0];
        pick_half = pick_rd ? rd_half[pick_ch] : wr_half[pick_ch];
        pick_off  = pick_rd ? rd_off[pick_ch] : wr_off[pick_ch];
        pick_addr = {pick_half, pick_ch, OFFA_W'(pick_off)};

        grant_now = (state == IDLE) && ctrl_idle && pick_valid;
        gch       = gnt_id[1];

        // A channel that holds or is just receiving a grant defers its clear
        for (int k = 0; k < 2; k++) begin
            ch_busy[k] = ((state == REQ) && (gnt_id[1] == 1'(k))) ||
                         (grant_now && (pick_ch == 1'(k)));
        end
    end

    // Grant FSM, per-channel offset/half bookkeeping and registered status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            sys_w_req   <= 1'b0;
            sys_r_req   <= 1'b0;
            sys_wr_addr <= '0;
            gnt_id      <= '0;
            gnt_valid   <= 1'b0;
            rd_ready    <= '0;
            w_stall     <= '0;
            wr_half     <= '0;
            rd_half     <= '0;
            clr_pend    <= '0;
            for (int k = 0; k < 2; k++) begin
                wr_off[k]     <= '0;
                rd_off[k]     <= '0;
                half_valid[k] <= '0;
            end
        end else begin
            rd_ready <= {|half_valid[1], |half_valid[0]};
            w_stall  <= stall_now;

            for (int k = 0; k < 2; k++) begin
                if (ch_clr[k]) begin
                    if (ch_busy[k]) begin
                        clr_pend[k] <= 1'b1;
                    end else begin
                        wr_off[k]     <= '0;
                        rd_off[k]     <= '0;
                        wr_half[k]    <= 1'b0;
                        rd_half[k]    <= 1'b0;
                        half_valid[k] <= '0;
                        clr_pend[k]   <= 1'b0;
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (grant_now) begin
                        gnt_id      <= pick_id;
                        sys_wr_addr <= pick_addr;
                        sys_w_req   <= !pick_rd;
                        sys_r_req   <= pick_rd;
                        gnt_valid   <= 1'b1;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (cmd_ack) begin
                        sys_w_req <= 1'b0;
                        sys_r_req <= 1'b0;
                        gnt_valid <= 1'b0;
                        rr_ptr    <= gnt_id + 2'd1;
                        state     <= GAP;
                        if (clr_pend[gch] || ch_clr[gch]) begin
                            wr_off[gch]     <= '0;
                            rd_off[gch]     <= '0;
                            wr_half[gch]    <= 1'b0;
                            rd_half[gch]    <= 1'b0;
                            half_valid[gch] <= '0;
                            clr_pend[gch]   <= 1'b0;
                        end else if (!gnt_id[0]) begin
                            if (wr_off[gch] == LAST_OFF) begin
                                wr_off[gch]                   <= '0;
                                half_valid[gch][wr_half[gch]] <= 1'b1;
                                wr_half[gch]                  <= ~wr_half[gch];
                            end else begin
                                wr_off[gch] <= wr_off[gch] + BURST_INC;
                            end
                        end else begin
                            if (rd_off[gch] == LAST_OFF) begin
                                rd_off[gch]                   <= '0;
                                half_valid[gch][rd_half[gch]] <= 1'b0;
                                rd_half[gch]                  <= ~rd_half[gch];
                            end else begin
                                rd_off[gch] <= rd_off[gch] + BURST_INC;
                            end
                        end
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Self-checking bench for sdram_burst_arbiter: transaction-level model of
// the ping-pong bookkeeping feeds a scoreboard of expected grants.
`timescale 1ns/1ps
module tb_sdram_burst_arbiter;

    localparam int unsigned ADDR_W  = 22;
    localparam int unsigned USEDW_W = 11;
    localparam int BL   = 8;
    localparam int BUFW = 1024;
    localparam int WM   = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               ctrl_idle;
    logic               cmd_ack;
    logic [USEDW_W-1:0] w0_usedw, r0_usedw, w1_usedw, r1_usedw;
    logic [1:0]         ch_clr;
    logic               sys_w_req, sys_r_req, gnt_valid;
    logic [ADDR_W-1:0]  sys_wr_addr;
    logic [1:0]         gnt_id, rd_ready, w_stall;

    sdram_burst_arbiter dut (
        .clk(clk), .rst_n(rst_n), .ctrl_idle(ctrl_idle), .cmd_ack(cmd_ack),
        .w0_usedw(w0_usedw), .r0_usedw(r0_usedw),
        .w1_usedw(w1_usedw), .r1_usedw(r1_usedw),
        .ch_clr(ch_clr), .sys_w_req(sys_w_req), .sys_r_req(sys_r_req),
        .sys_wr_addr(sys_wr_addr), .gnt_id(gnt_id), .gnt_valid(gnt_valid),
        .rd_ready(rd_ready), .w_stall(w_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]        id;
        logic [ADDR_W-1:0] addr;
    } exp_t;

    typedef struct {
        int w0;
        int r0;
        int w1;
        int r1;
        int exp_id;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[8];

    int checks = 0;
    int errors = 0;

    // Transaction-level model state
    int       m_wr_off[2];
    int       m_rd_off[2];
    bit       m_wr_half[2];
    bit       m_rd_half[2];
    bit [1:0] m_hv[2];
    int       m_rr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void m_clear(input int c);
        m_wr_off[c]  = 0;
        m_rd_off[c]  = 0;
        m_wr_half[c] = 1'b0;
        m_rd_half[c] = 1'b0;
        m_hv[c]      = 2'b00;
    endfunction

    function automatic void m_reset();
        m_clear(0);
        m_clear(1);
        m_rr = 0;
    endfunction

    function automatic int m_pick();
        bit [3:0] r;
        r[0] = (int'(w0_usedw) >= BL) && !m_hv[0][m_wr_half[0]];
        r[1] = m_hv[0][m_rd_half[0]] && (int'(r0_usedw) <= WM);
        r[2] = (int'(w1_usedw) >= BL) && !m_hv[1][m_wr_half[1]];
        r[3] = m_hv[1][m_rd_half[1]] && (int'(r1_usedw) <= WM);
        for (int i = 0; i < 4; i++) begin
            if (r[(m_rr + i) % 4]) return (m_rr + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [ADDR_W-1:0] m_addr(input int id);
        int c;
        bit rd;
        bit half;
        int off;
        c    = id / 2;
        rd   = (id % 2) == 1;
        half = rd ? m_rd_half[c] : m_wr_half[c];
        off  = rd ? m_rd_off[c] : m_wr_off[c];
        return {half, (c == 1), 20'(off)};
    endfunction

    function automatic void m_ack(input int id, input bit clr);
        int c;
        c = id / 2;
        if (clr) begin
            m_clear(c);
        end else if ((id % 2) == 0) begin
            if (m_wr_off[c] == BUFW - BL) begin
                m_wr_off[c] = 0;
                m_hv[c][m_wr_half[c]] = 1'b1;
                m_wr_half[c] = ~m_wr_half[c];
            end else begin
                m_wr_off[c] += BL;
            end
        end else begin
            if (m_rd_off[c] == BUFW - BL) begin
                m_rd_off[c] = 0;
                m_hv[c][m_rd_half[c]] = 1'b0;
                m_rd_half[c] = ~m_rd_half[c];
            end else begin
                m_rd_off[c] += BL;
            end
        end
        m_rr = (id + 1) % 4;
    endfunction

    task automatic set_levels(input int a, input int b, input int c, input int d);
        w0_usedw = USEDW_W'(a);
        r0_usedw = USEDW_W'(b);
        w1_usedw = USEDW_W'(c);
        r1_usedw = USEDW_W'(d);
    endtask

    task automatic push_id(input int id);
        exp_t e;
        e.id   = 2'(id);
        e.addr = m_addr(id);
        sb.push_back(e);
    endtask

    task automatic push_expect();
        int id;
        id = m_pick();
        if (id < 0) begin
            checks++;
            errors++;
            $display("FAIL predict: got no pending requester, expected one");
        end else begin
            push_id(id);
        end
    endtask

    // Wait for a request, compare with the scoreboard, hold dly cycles, ack
    task automatic serve_one(input int dly, input logic [1:0] clr);
        exp_t e;
        int   n;
        n = 0;
        while (!(sys_w_req || sys_r_req) && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!(sys_w_req || sys_r_req)) begin
            checks++;
            errors++;
            $display("FAIL grant_timeout: got no request in %0d cycles, expected one", n);
            if (sb.size() > 0) e = sb.pop_front();
            return;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_underflow: got request id %0d, expected none queued", gnt_id);
            return;
        end
        e = sb.pop_front();
        chk("gnt_id", 32'(gnt_id), 32'(e.id));
        chk("addr", 32'(sys_wr_addr), 32'(e.addr));
        chk("w_req", 32'(sys_w_req), 32'(!e.id[0]));
        chk("r_req", 32'(sys_r_req), 32'(e.id[0]));
        chk("gnt_valid", 32'(gnt_valid), 32'd1);
        ch_clr = clr;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            ch_clr = 2'b00;
            chk("hold_req", 32'(sys_w_req | sys_r_req), 32'd1);
            chk("hold_addr", 32'(sys_wr_addr), 32'(e.addr));
        end
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        ch_clr  = 2'b00;
        chk("req_drop", 32'({sys_w_req, sys_r_req, gnt_valid}), 32'd0);
        m_ack(int'(e.id), clr[e.id[1]]);
        @(negedge clk);
        chk("gap_no_grant", 32'({sys_w_req, sys_r_req, gnt_valid}), 32'd0);
    endtask

    task automatic burst(input int dly);
        push_expect();
        serve_one(dly, 2'b00);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion by 1ms, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        // Round-robin vectors: levels and the requester that must win next
        vecs[0] = '{8, 0,   8, 0,   3};
        vecs[1] = '{8, 0,   8, 0,   0};
        vecs[2] = '{8, 0,   8, 0,   1};
        vecs[3] = '{8, 0,   8, 0,   2};
        vecs[4] = '{8, 0,   8, 0,   3};
        vecs[5] = '{0, 100, 8, 0,   2};
        vecs[6] = '{8, 100, 0, 100, 0};
        vecs[7] = '{0, 0,   8, 100, 1};

        rst_n     = 1'b0;
        ctrl_idle = 1'b1;
        cmd_ack   = 1'b0;
        ch_clr    = 2'b00;
        set_levels(0, 100, 0, 100);
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_w_req", 32'(sys_w_req), 32'd0);
        chk("rst_r_req", 32'(sys_r_req), 32'd0);
        chk("rst_addr", 32'(sys_wr_addr), 32'd0);
        chk("rst_gnt", 32'({gnt_id, gnt_valid}), 32'd0);
        chk("rst_status", 32'({rd_ready, w_stall}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single writer, ack three cycles after the request
        set_levels(8, 100, 0, 100);
        burst(3);
        burst(0);

        // Fill half 0 of channel 0, then first burst of half 1
        for (int i = 0; i < 126; i++) burst(0);
        chk("rd_ready_half0", 32'(rd_ready), 32'd1);
        burst(1);
        for (int i = 0; i < 127; i++) burst(0);

        // Both halves full and unread: writer must stall
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("stall_no_wreq", 32'(sys_w_req | sys_r_req), 32'd0);
        end
        chk("w_stall0", 32'(w_stall), 32'd1);
        chk("rd_ready_full", 32'(rd_ready), 32'd1);

        // Drain one half through R0, then W0 resumes at half 0
        set_levels(8, 0, 0, 100);
        for (int i = 0; i < 128; i++) burst(0);
        burst(2);
        chk("w_stall_clear", 32'(w_stall), 32'd0);
        chk("rd_ready_after_read", 32'(rd_ready), 32'd1);

        // Fill half 0 of channel 1
        set_levels(0, 100, 8, 100);
        for (int i = 0; i < 128; i++) burst(0);
        chk("rd_ready_both", 32'(rd_ready), 32'd3);

        // Round-robin table
        foreach (vecs[i]) begin
            set_levels(vecs[i].w0, vecs[i].r0, vecs[i].w1, vecs[i].r1);
            push_id(vecs[i].exp_id);
            serve_one(1, 2'b00);
        end

        // Clear channel 1 while its write burst at offset 0x10 is granted
        set_levels(0, 100, 8, 100);
        push_expect();
        serve_one(2, 2'b10);
        burst(0);
        chk("rd_ready_ch1_clr", 32'(rd_ready), 32'd1);

        // Stray ack while idle, then clear both channels while idle
        set_levels(0, 100, 0, 100);
        cmd_ack = 1'b1;
        @(negedge clk);
        cmd_ack = 1'b0;
        ch_clr  = 2'b11;
        @(negedge clk);
        ch_clr = 2'b00;
        m_clear(0);
        m_clear(1);
        @(negedge clk);
        chk("idle_clr_rd_ready", 32'(rd_ready), 32'd0);
        chk("stray_ack_no_grant", 32'(gnt_valid), 32'd0);
        set_levels(0, 100, 8, 100);
        burst(0);

        // Reset in the middle of a W1 request
        set_levels(8, 100, 0, 100);
        burst(0);
        set_levels(0, 100, 8, 100);
        n = 0;
        while (!sys_w_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_req", 32'(sys_w_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_req", 32'({sys_w_req, sys_r_req, gnt_valid}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        set_levels(8, 100, 8, 100);
        burst(1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_burst_arbiter.md
Name: sdram_burst_arbiter

Overview:
- Schedules SDRAM burst transfers for two independent ping-pong channels (channel 0, channel 1) sharing one sdram_ctrl.
- Each channel has one write FIFO (system → SDRAM) and one read FIFO (SDRAM → system).
- Issues one sys_w_req/sys_r_req burst at a time, using round-robin among four requesters.
- Generates sys_wr_addr and tracks per-channel ping-pong half ownership so the reader never reads a half that is still being written.
- Sits between the FIFO pairs and sdram_ctrl in the two-port SDRAM top; gnt_id steers FIFO rreq/wreq muxing.

Parameters:
- BURST_LEN, 8: words per burst; power of 2.
- BUF_WORDS, 1024: words per ping-pong half; power-of-2 multiple of BURST_LEN, ≤ 2^(ADDR_W-2).
- ADDR_W, 22: sys_wr_addr width.
- USEDW_W, 11: FIFO used-word count width.
- RD_LOW_WM, 8: read FIFO level at or below which a read burst may be requested.

Ports:
- clk  in  1  system clock (same as sdram_ctrl).
- rst_n  in  1  asynchronous active-low reset.
- ctrl_idle  in  1  sdram_ctrl idle (ctrl_cmd == 2'b00).
- cmd_ack  in  1  sdram_ctrl burst accepted, one-cycle pulse.
- w0_usedw  in  USEDW_W  channel 0 write FIFO read-side used words.
- r0_usedw  in  USEDW_W  channel 0 read FIFO write-side used words.
- w1_usedw  in  USEDW_W  channel 1 write FIFO read-side used words.
- r1_usedw  in  USEDW_W  channel 1 read FIFO write-side used words.
- ch_clr  in  2  per-channel synchronous clear pulse.
- sys_w_req  out  1  write burst request to sdram_ctrl.
- sys_r_req  out  1  read burst request to sdram_ctrl.
- sys_wr_addr  out  ADDR_W  burst start address.
- gnt_id  out  2  active requester: 0=W0, 1=R0, 2=W1, 3=R1.
- gnt_valid  out  1  a grant is active (REQ state).
- rd_ready  out  2  per channel: at least one half is valid.
- w_stall  out  2  per channel: write FIFO has a burst available but the target half is still unread.

Behaviour:

Reset and clock:
- rst_n is asynchronous, active-low; clock is clk.
- Reset values: all outputs 0, FSM in IDLE, rr_ptr=0.
- Per-channel state at reset: wr_off=rd_off=0, wr_half=rd_half=0, half_valid=2'b00.

Request rules (combinational, per channel k):
- wreq_k = (wk_usedw ≥ BURST_LEN) && !half_valid_k[wr_half_k].
- rreq_k = half_valid_k[rd_half_k] && (rk_usedw ≤ RD_LOW_WM).
- w_stall_k = (wk_usedw ≥ BURST_LEN) && half_valid_k[wr_half_k].
- rd_ready_k = |half_valid_k.

FSM states: IDLE, REQ, GAP.
- IDLE:
  - If ctrl_idle and any request is pending: select the first pending requester starting at rr_ptr, in order 0,1,2,3 with wrap.
  - Register gnt_id and sys_wr_addr, then go to REQ.
  - sys_w_req or sys_r_req asserts in the first REQ cycle (one cycle after the decision).
- REQ:
  - Hold the request, gnt_id and address stable until cmd_ack.
  - On cmd_ack: deassert the request in the next cycle, update the granted channel, set rr_ptr = gnt_id+1 (mod 4), go to GAP.
- GAP:
  - One cycle to let ctrl_idle fall, then go to IDLE.
  - A new grant is never issued in the cycle after cmd_ack.

Addressing:
- sys_wr_addr = {half, ch, off[ADDR_W-3:0]}.
- half is wr_half for writes, rd_half for reads.
- off is wr_off or rd_off, zero-extended.

Counter update on cmd_ack:
- Write grant, off ≠ BUF_WORDS-BURST_LEN: wr_off += BURST_LEN.
- Write grant, last burst of the half: wr_off=0, half_valid[wr_half]=1, wr_half toggles.
- Read grant: symmetric with rd_off/rd_half; on the last burst of the half, half_valid[rd_half] is cleared instead of set.
- Only one grant is active at a time, so set and clear of half_valid never coincide.

ch_clr[k]:
- Not granted: next cycle resets channel k offsets, halves and half_valid to 0.
- Channel k currently granted: the clear is latched and applied on the cmd_ack update; it overrides the normal increment.

Other rules:
- cmd_ack outside REQ: ignored.
- Reset mid-burst: outputs drop to 0 asynchronously.

Test Plan:
- Single writer: w0_usedw=8, ctrl_idle=1, cmd_ack 3 cycles after request → sys_w_req=1, addr=0x000000, gnt_id=0; after ack, next W0 address = 0x000008.
- Half fill: 128 W0 bursts acked → half_valid0=2'b01, rd_ready[0]=1; next W0 address = 0x200000 (half bit set).
- Ping-pong stall: both halves of channel 0 filled, none read → w_stall[0]=1, no W0 request. One full half read (128 R0 acks, r0_usedw=0) → half_valid0=2'b10, W0 resumes at address 0x000000.
- Round-robin: all four requests pending continuously → grant order 0,1,2,3,0. Each grant separated by REQ and GAP; no back-to-back grant in the cycle after cmd_ack.
- ch_clr[1] pulse while W1 granted at off=0x10 → on ack, channel 1 offsets reset to 0 rather than 0x18. ch_clr[1] while idle → clears in 1 cycle.
- rst_n low during REQ → sys_w_req, sys_r_req, gnt_valid go 0 immediately. After release, first grant is W0 at address 0.
